// File: rtl/npcnn_pkg.sv
// Shared types, widths and sizing helpers for the npcnn convolution engine.
package npcnn_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned W_W    = 9;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned ACC_W  = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_MAC,
    S_CLEAR,
    S_OUT
  } state_t;

  function automatic int calc_os(int as, int bs, int s, int p);
    return (as + 2 * p - bs) / s + 1;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned clogb(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/npcnn_mac.sv
// Single multiply-accumulate: zero-extended pixel times signed weight into a wrapping 20-bit accumulator.
module npcnn_mac
  import npcnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PIX_W-1:0] pix,
  input  logic [W_W-1:0]   w,
  output logic [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] pix_s, w_s, prod;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  always_comb begin
    pix_s = PROD_W'($signed({1'b0, pix}));
    w_s   = PROD_W'($signed(w));
    prod  = pix_s * w_s;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/npcnn.sv
// Serial-load 2-D convolution engine with one MAC; optional ReLU on stored results via NPCNN_RELU_EN.
module npcnn
  import npcnn_pkg::*;
#(
  parameter int AS = 6,
  parameter int BS = 3,
  parameter int S  = 1,
  parameter int P  = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ACC_W-1:0] out,
  output logic             done,
  input  logic [PIX_W-1:0] a,
  input  logic [W_W-1:0]   b,
  input  logic             go
);

  localparam int          OS   = calc_os(AS, BS, S, P);
  localparam int unsigned NA   = AS * AS;
  localparam int unsigned NB   = BS * BS;
  localparam int unsigned NO   = OS * OS;
  localparam int unsigned LD_W = clogb((NA > NB) ? NA : NB);
  localparam int unsigned IA_W = clogb(NA);
  localparam int unsigned KA_W = clogb(NB);
  localparam int unsigned KS_W = clogb(BS);
  localparam int unsigned OS_W = clogb(OS);
  localparam int unsigned OA_W = clogb(NO);

  logic [PIX_W-1:0] img_mem  [NA];
  logic [W_W-1:0]   ker_mem  [NB];
  logic [ACC_W-1:0] obuf_mem [NO];

  state_t            state_d, state_q;
  logic [LD_W-1:0]   ld_d, ld_q;
  logic [KS_W-1:0]   ki_d, ki_q, kj_d, kj_q;
  logic [KA_W-1:0]   k_d, k_q;
  logic [OS_W-1:0]   r_d, r_q, c_d, c_q;
  logic [OA_W-1:0]   o_d, o_q;
  logic [ACC_W-1:0]  out_d, out_q;
  logic              done_d, done_q;

  logic              img_we, ker_we, obuf_we, mac_en, mac_clr;
  logic [PIX_W-1:0]  pix_c;
  logic [W_W-1:0]    wgt_c;
  logic [ACC_W-1:0]  acc_c, wdata_c;
  int                ir_c, ic_c;

  // Image coordinate addressed by the current kernel tap; outside the image reads as padding.
  always_comb begin
    ir_c  = int'(r_q) * S + int'(ki_q) - P;
    ic_c  = int'(c_q) * S + int'(kj_q) - P;
    pix_c = '0;
    if (ir_c >= 0 && ir_c < AS && ic_c >= 0 && ic_c < AS) begin
      pix_c = img_mem[IA_W'(ir_c * AS + ic_c)];
    end
    wgt_c = ker_mem[k_q];
`ifdef NPCNN_RELU_EN
    wdata_c = acc_c[ACC_W-1] ? '0 : acc_c;
`else
    wdata_c = acc_c;
`endif
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    o_d     = o_q;
    out_d   = out_q;
    done_d  = 1'b0;
    img_we  = 1'b0;
    ker_we  = 1'b0;
    obuf_we = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        mac_clr = 1'b1;
        if (go) begin
          state_d = S_LOAD_A;
          ld_d    = '0;
          ki_d    = '0;
          kj_d    = '0;
          k_d     = '0;
          r_d     = '0;
          c_d     = '0;
          o_d     = '0;
        end
      end
      S_LOAD_A: begin
        img_we = 1'b1;
        ld_d   = ld_q + LD_W'(1);
        if (ld_q == LD_W'(NA - 1)) begin
          ld_d    = '0;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        ker_we = 1'b1;
        ld_d   = ld_q + LD_W'(1);
        if (ld_q == LD_W'(NB - 1)) begin
          ld_d    = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + KA_W'(1);
        kj_d   = kj_q + KS_W'(1);
        if (kj_q == KS_W'(BS - 1)) begin
          kj_d = '0;
          ki_d = ki_q + KS_W'(1);
        end
        if (k_q == KA_W'(NB - 1)) begin
          k_d     = '0;
          ki_d    = '0;
          kj_d    = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        obuf_we = 1'b1;
        mac_clr = 1'b1;
        o_d     = o_q + OA_W'(1);
        c_d     = c_q + OS_W'(1);
        state_d = S_MAC;
        if (c_q == OS_W'(OS - 1)) begin
          c_d = '0;
          r_d = r_q + OS_W'(1);
        end
        if (o_q == OA_W'(NO - 1)) begin
          o_d     = '0;
          r_d     = '0;
          c_d     = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        done_d = 1'b1;
        out_d  = obuf_mem[o_q];
        o_d    = o_q + OA_W'(1);
        if (o_q == OA_W'(NO - 1)) begin
          o_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
      ki_q    <= '0;
      kj_q    <= '0;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      o_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      ki_q    <= ki_d;
      kj_q    <= kj_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      o_q     <= o_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Buffers keep their contents across reset; each run reloads them.
  always_ff @(posedge clk) begin
    if (img_we)  img_mem[IA_W'(ld_q)] <= a;
    if (ker_we)  ker_mem[KA_W'(ld_q)] <= b;
    if (obuf_we) obuf_mem[o_q]        <= wdata_c;
  end

  npcnn_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .clr   (mac_clr),
    .pix   (pix_c),
    .w     (wgt_c),
    .acc   (acc_c)
  );

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_npcnn.sv
// Bench for npcnn: default, stride-2 and pad-1 instances share stimulus; results checked against a loop model.
module tb_npcnn;

  logic        clk, reset, go;
  logic [7:0]  a;
  logic [8:0]  b;
  logic [19:0] out0, out1, out2;
  logic        done0, done1, done2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int img_t [36];
  int ker_t [9];
  logic [19:0] q0[$], q1[$], q2[$];
  int f0, l0, f1, l1, f2, l2;

  npcnn u_dflt (.clk(clk), .reset(reset), .out(out0), .done(done0), .a(a), .b(b), .go(go));
  npcnn #(.S(2)) u_s2 (.clk(clk), .reset(reset), .out(out1), .done(done1), .a(a), .b(b), .go(go));
  npcnn #(.P(1)) u_p1 (.clk(clk), .reset(reset), .out(out2), .done(done2), .a(a), .b(b), .go(go));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every valid output with the cycle it appeared on, relative to the go edge.
  always @(negedge clk) begin
    if (done0) begin q0.push_back(out0); if (f0 < 0) f0 = cyc - t0; l0 = cyc - t0; end
    if (done1) begin q1.push_back(out1); if (f1 < 0) f1 = cyc - t0; l1 = cyc - t0; end
    if (done2) begin q2.push_back(out2); if (f2 < 0) f2 = cyc - t0; l2 = cyc - t0; end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int exp_px(int r, int c, int s, int p);
    int sum, ir, ic;
    logic [19:0] w;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ir = r * s + i - p;
        ic = c * s + j - p;
        if (ir >= 0 && ir < 6 && ic >= 0 && ic < 6) sum += img_t[ir * 6 + ic] * ker_t[i * 3 + j];
      end
    end
    w = 20'(sum);
`ifdef NPCNN_RELU_EN
    if (w[19]) w = '0;
`endif
    return int'(w);
  endfunction

  task automatic set_pattern(input int kind);
    for (int i = 0; i < 36; i++) begin
      case (kind)
        0:       img_t[i] = 1;
        1, 3:    img_t[i] = 255;
        2:       img_t[i] = i;
        default: img_t[i] = int'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < 9; i++) begin
      case (kind)
        0:       ker_t[i] = 1;
        1:       ker_t[i] = -1;
        2:       ker_t[i] = (i == 4) ? 1 : 0;
        3:       ker_t[i] = 255;
        default: ker_t[i] = int'($urandom_range(0, 511)) - 256;
      endcase
    end
  endtask

  // Called just after a clock edge; go is sampled on the next edge (cycle 0).
  task automatic start_run();
    q0.delete(); q1.delete(); q2.delete();
    f0 = -1; f1 = -1; f2 = -1; l0 = -1; l1 = -1; l2 = -1;
    go = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    go = 1'b0;
    for (int i = 0; i < 36; i++) begin a = 8'(img_t[i]); @(posedge clk); #1; end
    for (int i = 0; i < 9; i++)  begin b = 9'(ker_t[i]); @(posedge clk); #1; end
  endtask

  task automatic cmp_inst(input string tag, input logic [19:0] q[$], input int s, input int p,
                          input int f, input int l);
    int os, last;
    os   = (6 + 2 * p - 3) / s + 1;
    last = 1 + 36 + 9 + 10 * os * os + os * os - 1;
    chk({tag, "_cnt"}, q.size(), os * os);
    chk({tag, "_first"}, f, last - os * os + 1);
    chk({tag, "_last"}, l, last);
    for (int i = 0; i < q.size() && i < os * os; i++)
      chk($sformatf("%s_o%0d", tag, i), int'(q[i]), exp_px(i / os, i % os, s, p));
  endtask

  task automatic run_check(input string tag);
    start_run();
    repeat (460) @(posedge clk);
    #1;
    cmp_inst({tag, "_dflt"}, q0, 1, 0, f0, l0);
    cmp_inst({tag, "_s2"},   q1, 2, 0, f1, l1);
    cmp_inst({tag, "_p1"},   q2, 1, 1, f2, l2);
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done0", int'(done0), 0); chk("rst_out0", int'(out0), 0);
    chk("rst_done1", int'(done1), 0); chk("rst_out1", int'(out1), 0);
    chk("rst_done2", int'(done2), 0); chk("rst_out2", int'(out2), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    set_pattern(0); run_check("ones");
    if (q0.size() == 16) begin chk("ones_v0", int'(q0[0]), 9); chk("ones_v15", int'(q0[15]), 9); end
    if (q2.size() == 36) begin
      chk("pad_corner", int'(q2[0]), 4); chk("pad_edge", int'(q2[1]), 6); chk("pad_inner", int'(q2[7]), 9);
    end

    set_pattern(1); run_check("neg");
`ifdef NPCNN_RELU_EN
    if (q0.size() == 16) chk("neg_v0", int'(q0[0]), 0);
`else
    if (q0.size() == 16) chk("neg_v0", int'(q0[0]), 32'hFF709);
`endif

    set_pattern(2); run_check("ramp");
    if (q0.size() == 16) begin chk("ramp_00", int'(q0[0]), 7); chk("ramp_33", int'(q0[15]), 28); end

    set_pattern(3); run_check("wrap");
    for (int t = 0; t < 3; t++) begin set_pattern(4); run_check($sformatf("rnd%0d", t)); end

    // Abort a run in the middle of accumulation.
    set_pattern(4);
    start_run();
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_done0", int'(done0), 0); chk("abort_out0", int'(out0), 0);
    chk("abort_done1", int'(done1), 0); chk("abort_out1", int'(out1), 0);
    chk("abort_done2", int'(done2), 0); chk("abort_out2", int'(out2), 0);
    chk("abort_nodone", q0.size() + q1.size() + q2.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    set_pattern(4); run_check("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
